pi_controller_fixed: RTL and testbench

Fixed-point PI controller that sits directly downstream of filter_basic. It consumes the filtered feedback value and a setpoint, and produces a saturated control command once per sample strobe. The integrator has anti-windup, and a handshake tells the actuator stage when a new command is ready.

---
 rtl/pi_ctrl_pkg.sv | 31 +++
 rtl/sat_clamp.sv | 19 +
 rtl/pi_controller_fixed.sv | 151 +++++++++++++++
 tb/tb_pi_controller_fixed.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pi_ctrl_pkg.sv
// Shared types, width helpers and the signed saturation function for the PI controller.
package pi_ctrl_pkg;

  // Widest value any clamp in this block ever has to handle.
  localparam int SAT_W = 128;

  function automatic int acc_w(input int reg_max);
    return 2 * reg_max;
  endfunction

  localparam int ACC_W = acc_w(32);

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL,
    ACC,
    OUT
  } state_e;

  function automatic logic signed [SAT_W-1:0] sat_fn(
    input logic signed [SAT_W-1:0] v,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clamp: sign-extends din, limits it to [LO, HI] and narrows to OUT_W.
module sat_clamp
  import pi_ctrl_pkg::*;
#(
  parameter int                      IN_W  = 33,
  parameter int                      OUT_W = 32,
  parameter logic signed [SAT_W-1:0] LO    = -SAT_W'(1),
  parameter logic signed [SAT_W-1:0] HI    = SAT_W'(1)
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // Bounds always fit in OUT_W, so dropping the upper bits after clamping loses nothing.
  always_comb begin
    dout = OUT_W'(sat_fn(SAT_W'(din), LO, HI));
  end

endmodule

// File: rtl/pi_controller_fixed.sv
// Fixed-point PI controller with clamped integrator (anti-windup) and saturated,
// registered output; one sample is processed over a 5-state pipeline-less FSM.
module pi_controller_fixed
  import pi_ctrl_pkg::*;
#(
  parameter int REG_MAX   = 32,
  parameter int FRAC_BITS = 4,
  parameter int KP        = 32,
  parameter int KI        = 8,
  parameter int INT_LIM   = 100000,
  parameter int OUT_MAX   = 1000000,
  parameter int OUT_MIN   = -1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      sample_en,
  input  logic signed [REG_MAX-1:0] setpoint,
  input  logic signed [REG_MAX-1:0] feedback,
  output logic signed [REG_MAX-1:0] control_out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int PROD_W = acc_w(REG_MAX);

  localparam logic signed [SAT_W-1:0] ERR_HI = (SAT_W'(1) <<< (REG_MAX - 1)) - 1;
  localparam logic signed [SAT_W-1:0] ERR_LO = -ERR_HI - 1;
  localparam logic signed [SAT_W-1:0] INT_HI = SAT_W'(INT_LIM);
  localparam logic signed [SAT_W-1:0] INT_LO = SAT_W'(-INT_LIM);
  localparam logic signed [SAT_W-1:0] OUT_HI = SAT_W'(OUT_MAX);
  localparam logic signed [SAT_W-1:0] OUT_LO = SAT_W'(OUT_MIN);

  state_e                    state_q, state_d;
  logic signed [REG_MAX-1:0] sp_q, sp_d, fb_q, fb_d;
  logic signed [REG_MAX-1:0] err_q, err_d;
  logic signed [PROD_W-1:0]  p_q, p_d, iinc_q, iinc_d;
  logic signed [REG_MAX-1:0] integ_q, integ_d;
  logic signed [PROD_W:0]    sum_q, sum_d;
  logic signed [REG_MAX-1:0] ctrl_q, ctrl_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;

  logic signed [REG_MAX:0]   err_raw;
  logic signed [REG_MAX-1:0] err_sat;
  logic signed [PROD_W:0]    integ_raw;
  logic signed [REG_MAX-1:0] integ_sat;
  logic signed [REG_MAX-1:0] ctrl_sat;

  // One extra bit so setpoint - feedback can never wrap before it is clamped.
  assign err_raw   = (REG_MAX+1)'(sp_q) - (REG_MAX+1)'(fb_q);
  assign integ_raw = (PROD_W+1)'(integ_q) + (PROD_W+1)'(iinc_q);

  sat_clamp #(.IN_W(REG_MAX+1), .OUT_W(REG_MAX), .LO(ERR_LO), .HI(ERR_HI))
    u_err_clamp (.din(err_raw), .dout(err_sat));

  sat_clamp #(.IN_W(PROD_W+1), .OUT_W(REG_MAX), .LO(INT_LO), .HI(INT_HI))
    u_int_clamp (.din(integ_raw), .dout(integ_sat));

  sat_clamp #(.IN_W(PROD_W+1), .OUT_W(REG_MAX), .LO(OUT_LO), .HI(OUT_HI))
    u_out_clamp (.din(sum_q), .dout(ctrl_sat));

  // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    fb_d    = fb_q;
    err_d   = err_q;
    p_d     = p_q;
    iinc_d  = iinc_q;
    integ_d = integ_q;
    sum_d   = sum_q;
    ctrl_d  = ctrl_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q | (sample_en & (state_q != IDLE));

    if (!enable) begin
      state_d = IDLE;
      integ_d = '0;
      ctrl_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sample_en) begin
            sp_d    = setpoint;
            fb_d    = feedback;
            state_d = ERR;
          end
        end
        ERR: begin
          err_d   = err_sat;
          state_d = MUL;
        end
        MUL: begin
          // Signed operands make >>> arithmetic, i.e. rounding toward -inf.
          p_d     = (PROD_W'(err_q) * PROD_W'(KP)) >>> FRAC_BITS;
          iinc_d  = (PROD_W'(err_q) * PROD_W'(KI)) >>> FRAC_BITS;
          state_d = ACC;
        end
        ACC: begin
          integ_d = integ_sat;
          sum_d   = (PROD_W+1)'(p_q) + (PROD_W+1)'(integ_sat);
          state_d = OUT;
        end
        OUT: begin
          ctrl_d  = ctrl_sat;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every flop is reset here, so an in-flight sample is fully discarded.
      state_q <= IDLE;
      sp_q    <= '0;
      fb_q    <= '0;
      err_q   <= '0;
      p_q     <= '0;
      iinc_q  <= '0;
      integ_q <= '0;
      sum_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      fb_q    <= fb_d;
      err_q   <= err_d;
      p_q     <= p_d;
      iinc_q  <= iinc_d;
      integ_q <= integ_d;
      sum_q   <= sum_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign control_out = ctrl_q;
  assign out_valid   = valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_pi_controller_fixed.sv
// Directed bench for pi_controller_fixed: hand-computed results for step, windup,
// overrun, enable drop and mid-computation reset.
module tb_pi_controller_fixed;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               enable = 1'b0;
  logic               sample_en = 1'b0;
  logic signed [31:0] setpoint = '0;
  logic signed [31:0] feedback = '0;
  logic signed [31:0] control_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;

  always #5 clk = ~clk;

  pi_controller_fixed dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .sample_en  (sample_en),
    .setpoint   (setpoint),
    .feedback   (feedback),
    .control_out(control_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun)
  );

  always @(negedge clk) if (out_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    enable    = 1'b0;
    sample_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Strobe one sample and wait (bounded) for its result.
  task automatic run_sample(input int sp, input int fb, input int exp, input string tag);
    int n;
    setpoint  = sp;
    feedback  = fb;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    setpoint  = 32'sd77;
    feedback  = -32'sd77;
    check({tag, "_busy_start"}, busy, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_value"}, control_out, exp);
    check({tag, "_busy_end"}, busy, 0);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    // 1. Reset hold and release.
    repeat (3) @(negedge clk);
    check("rst_hold_busy", busy, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ctrl", control_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // 2. Positive step: p=2000, i=500 then i=1000.
    enable = 1'b1;
    run_sample(1000, 0, 2500, "pos1");
    run_sample(1000, 0, 3000, "pos2");

    // Reset asserted while in MUL discards the sample at once.
    setpoint  = 1000;
    feedback  = 0;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    @(negedge clk);
    check("mul_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("mulrst_ctrl", control_out, 0);
    check("mulrst_busy", busy, 0);
    check("mulrst_valid", out_valid, 0);
    p0 = pulses;
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("mulrst_no_pulse", pulses, p0);

    // 3. Negative error.
    do_reset();
    enable = 1'b1;
    run_sample(0, 1000, -2500, "neg1");
    run_sample(0, 1000, -3000, "neg2");

    // 4. Windup: p=2e6, integrator pinned at 1e5, output pinned at 1e6.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) run_sample(1000000, 0, 1000000, "wind");
    run_sample(500, 500, 100000, "unwind");

    // 5. Overrun: second strobe two cycles in is ignored but flagged.
    do_reset();
    enable = 1'b1;
    check("ovr_initial", overrun, 0);
    p0        = pulses;
    setpoint  = 1000;
    feedback  = 0;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    setpoint  = 5000;
    @(negedge clk);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check("ovr_set", overrun, 1);
    repeat (6) @(negedge clk);
    check("ovr_one_pulse", pulses, p0 + 1);
    check("ovr_first_result", control_out, 2500);
    run_sample(1000, 0, 3000, "ovr_next");
    check("ovr_sticky", overrun, 1);

    // 6. Enable drop clears integrator and output; strobe with enable low is ignored.
    do_reset();
    enable = 1'b1;
    run_sample(1000, 0, 2500, "en1");
    enable    = 1'b0;
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    check("endrop_ctrl", control_out, 0);
    check("endrop_valid", out_valid, 0);
    check("endrop_busy", busy, 0);
    enable = 1'b1;
    run_sample(1000, 0, 2500, "en2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
